// File: rtl/block_load_ctrl.sv
// block_load_ctrl
// Collects four 32-bit upstream words into a 128-bit block, strobes the block
// into the downstream data register for one cycle, fires a one-cycle start
// pulse to the downstream core and waits for it to report completion.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   in_valid     upstream word valid
//   in_word      upstream data word (32 bits)
//   in_ready     word accepted this cycle (only while collecting)
//   abort        synchronous flush of the block in progress
//   data_load    one-cycle load strobe to the 128-bit data register
//   data_in      assembled block, word 0 in the most significant slot
//   core_start   one-cycle start pulse to the downstream core
//   core_done    downstream core finished the current block
//   busy         block in progress (not collecting, or words pending)
//   blk_cnt      completed-block counter, wraps at 16 bits
//   timeout_err  watchdog expiry pulse (only with BLOCK_LOAD_TIMEOUT_EN)
//
// Optional feature: define BLOCK_LOAD_TIMEOUT_EN to add an 8-bit RUN-state
// watchdog that abandons a block when the core never reports done.

module block_load_ctrl (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  input  logic [31:0]  in_word,
  output logic         in_ready,
  input  logic         abort,
  output logic         data_load,
  output logic [127:0] data_in,
  output logic         core_start,
  input  logic         core_done,
  output logic         busy,
  output logic [15:0]  blk_cnt
`ifdef BLOCK_LOAD_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [1:0]     word_cnt_r;
  logic [127:0]   asm_r;
  logic [15:0]    blk_cnt_r;
  logic           start_r;
  logic           capture_s;
  logic           blk_inc_s;
  logic           timeout_hit_s;

`ifdef BLOCK_LOAD_TIMEOUT_EN
  logic [7:0]     wd_r;
  logic           timeout_r;

  // The 255th RUN cycle without done is the one where the count reads 254.
  assign timeout_hit_s = (wd_r == 8'd254);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    blk_inc_s    = 1'b0;
    in_ready     = 1'b0;
    data_load    = 1'b0;
    case (state_r)
      COLLECT: begin
        in_ready = 1'b1;
        // abort wins over a same-cycle handshake: nothing is captured
        if (abort) begin
          next_state_s = COLLECT;
        end else if (in_valid) begin
          capture_s = 1'b1;
          if (word_cnt_r == 2'd3) begin
            next_state_s = LOAD;
          end else begin
            next_state_s = COLLECT;
          end
        end else begin
          next_state_s = COLLECT;
        end
      end
      LOAD: begin
        // strobe is state-decoded, so it stays high even if abort arrives
        data_load = 1'b1;
        if (abort) begin
          next_state_s = COLLECT;
        end else begin
          next_state_s = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state_s = COLLECT;
        end else if (core_done) begin
          blk_inc_s    = 1'b1;
          next_state_s = COLLECT;
        end else if (timeout_hit_s) begin
          next_state_s = COLLECT;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = COLLECT;
      end
    endcase
  end

  // Word counter: wraps to 0 after the fourth word, cleared by abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_cnt_r <= 2'd0;
    end else if (abort) begin
      word_cnt_r <= 2'd0;
    end else if (capture_s) begin
      word_cnt_r <= word_cnt_r + 2'd1;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  // Assembly register: word 0 lands in the top slot, word 3 in the bottom.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      asm_r <= 128'd0;
    end else if (capture_s) begin
      case (word_cnt_r)
        2'd0:    asm_r[127:96] <= in_word;
        2'd1:    asm_r[95:64]  <= in_word;
        2'd2:    asm_r[63:32]  <= in_word;
        2'd3:    asm_r[31:0]   <= in_word;
        default: asm_r         <= asm_r;
      endcase
    end else begin
      asm_r <= asm_r;
    end
  end

  // Completed-block counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blk_cnt_r <= 16'd0;
    end else if (blk_inc_s) begin
      blk_cnt_r <= blk_cnt_r + 16'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  // Marks the first RUN cycle; an aborted LOAD never enters RUN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_r <= 1'b0;
    end else begin
      start_r <= (state_r == LOAD) && !abort;
    end
  end

`ifdef BLOCK_LOAD_TIMEOUT_EN
  // Watchdog: cleared on RUN entry, counts RUN cycles without done.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_r      <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == LOAD) begin
        wd_r <= 8'd0;
      end else if ((state_r == RUN) && !core_done && !abort) begin
        wd_r <= wd_r + 8'd1;
      end else begin
        wd_r <= wd_r;
      end
      timeout_r <= (state_r == RUN) && !abort && !core_done && timeout_hit_s;
    end
  end

  assign timeout_err = timeout_r;
`endif

  assign core_start = start_r;
  assign data_in    = asm_r;
  assign blk_cnt    = blk_cnt_r;
  assign busy       = (state_r != COLLECT) || (word_cnt_r != 2'd0);

endmodule

// File: tb/tb_block_load_ctrl.sv
// Directed testbench for block_load_ctrl. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, after state settles.
// Define BLOCK_LOAD_TIMEOUT_EN to also exercise the watchdog.

module tb_block_load_ctrl;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic [31:0]  in_word;
  logic         in_ready;
  logic         abort;
  logic         data_load;
  logic [127:0] data_in;
  logic         core_start;
  logic         core_done;
  logic         busy;
  logic [15:0]  blk_cnt;
`ifdef BLOCK_LOAD_TIMEOUT_EN
  logic         timeout_err;
`endif

  int           checks;
  int           errors;
  logic [15:0]  exp_blk;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

  block_load_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .abort      (abort),
    .data_load  (data_load),
    .data_in    (data_in),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .blk_cnt    (blk_cnt)
`ifdef BLOCK_LOAD_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches the summary.
  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_word  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b);
    send_word(b[127:96]);
    send_word(b[95:64]);
    send_word(b[63:32]);
    send_word(b[31:0]);
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #2;
    n_rst = 1'b0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || data_load !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b load=%b start=%b busy=%b exp 1 0 0 0",
               in_ready, data_load, core_start, busy);
    end
    checks++;
    if (data_in !== 128'd0 || blk_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data data_in=%h blk_cnt=%h exp 0 0", data_in, blk_cnt);
    end
    n_rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b exp 1 0", in_ready, busy);
    end
    exp_blk = 16'd0;
  endtask

  task automatic test_back_to_back();
    send_word(32'h00112233);
    send_word(32'h44556677);
    send_word(32'h8899AABB);
    checks++;
    if (data_load !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre load=%b busy=%b ready=%b exp 0 1 1", data_load, busy, in_ready);
    end
    send_word(32'hCCDDEEFF);
    checks++;
    if (data_load !== 1'b1 || in_ready !== 1'b0 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load load=%b ready=%b start=%b exp 1 0 0", data_load, in_ready, core_start);
    end
    checks++;
    if (data_in !== BLK_A) begin
      errors++;
      $display("FAIL b2b_data data_in=%h exp %h", data_in, BLK_A);
    end
    step();
    checks++;
    if (core_start !== 1'b1 || data_load !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start start=%b load=%b ready=%b exp 1 0 0", core_start, data_load, in_ready);
    end
    step();
    checks++;
    if (core_start !== 1'b0 || busy !== 1'b1 || data_in !== BLK_A) begin
      errors++;
      $display("FAIL b2b_run start=%b busy=%b data_in=%h exp 0 1 %h", core_start, busy, data_in, BLK_A);
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    exp_blk = exp_blk + 16'd1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL b2b_done ready=%b busy=%b blk_cnt=%h exp 1 0 %h", in_ready, busy, blk_cnt, exp_blk);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w [4];
    w[0] = 32'h00112233;
    w[1] = 32'h44556677;
    w[2] = 32'h8899AABB;
    w[3] = 32'hCCDDEEFF;
    // core_done while collecting must not count
    core_done = 1'b1;
    step();
    step();
    core_done = 1'b0;
    checks++;
    if (blk_cnt !== exp_blk || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_ignored blk_cnt=%h busy=%b exp %h 0", blk_cnt, busy, exp_blk);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(w[i]);
      for (int g = 0; g < 2; g++) begin
        step();
        checks++;
        if (in_ready !== 1'b1 || data_load !== 1'b0) begin
          errors++;
          $display("FAIL gap_ready word=%0d ready=%b load=%b exp 1 0", i, in_ready, data_load);
        end
      end
    end
    send_word(w[3]);
    checks++;
    if (data_load !== 1'b1 || data_in !== BLK_A) begin
      errors++;
      $display("FAIL gap_load load=%b data_in=%h exp 1 %h", data_load, data_in, BLK_A);
    end
    step();
    checks++;
    if (core_start !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gap_start start=%b ready=%b exp 1 0", core_start, in_ready);
    end
    // done in the start cycle completes the block
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    exp_blk = exp_blk + 16'd1;
    checks++;
    if (in_ready !== 1'b1 || blk_cnt !== exp_blk || core_start !== 1'b0) begin
      errors++;
      $display("FAIL done_in_start ready=%b blk_cnt=%h start=%b exp 1 %h 0", in_ready, blk_cnt, core_start, exp_blk);
    end
  endtask

  task automatic test_abort();
    send_word(32'h11111111);
    send_word(32'h22222222);
    in_valid = 1'b1;
    in_word  = 32'h33333333;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL abort_collect busy=%b ready=%b blk_cnt=%h exp 0 1 %h", busy, in_ready, blk_cnt, exp_blk);
    end
    send_block(BLK_B);
    checks++;
    if (data_load !== 1'b1 || data_in !== BLK_B) begin
      errors++;
      $display("FAIL abort_reassemble load=%b data_in=%h exp 1 %h", data_load, data_in, BLK_B);
    end
    // abort during LOAD: strobe already seen above, no start afterwards
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (core_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_load start=%b busy=%b ready=%b exp 0 0 1", core_start, busy, in_ready);
    end
    step();
    checks++;
    if (core_start !== 1'b0 || data_in !== BLK_B || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL abort_load_after start=%b data_in=%h blk_cnt=%h exp 0 %h %h", core_start, data_in, blk_cnt, BLK_B, exp_blk);
    end
    // abort in RUN beats a same-cycle core_done
    send_block(BLK_A);
    step();
    abort     = 1'b1;
    core_done = 1'b1;
    step();
    abort     = 1'b0;
    core_done = 1'b0;
    checks++;
    if (blk_cnt !== exp_blk || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_run blk_cnt=%h ready=%b busy=%b exp %h 1 0", blk_cnt, in_ready, busy, exp_blk);
    end
  endtask

  task automatic test_wrap();
    force dut.blk_cnt_r = 16'hFFFF;
    step();
    release dut.blk_cnt_r;
    step();
    checks++;
    if (blk_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preset blk_cnt=%h exp ffff", blk_cnt);
    end
    send_block(BLK_A);
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    exp_blk = 16'h0000;
    checks++;
    if (blk_cnt !== exp_blk || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap blk_cnt=%h ready=%b exp %h 1", blk_cnt, in_ready, exp_blk);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int b = 0; b < 5; b++) begin
      send_block(BLK_B);
      step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      exp_blk = exp_blk + 16'd1;
    end
    checks++;
    if (blk_cnt !== 16'd5 || exp_blk !== 16'd5) begin
      errors++;
      $display("FAIL five_blocks blk_cnt=%h exp 0005", blk_cnt);
    end
    send_block(BLK_A);
    step();
    // reset lands in the core_start cycle and must take effect at once
    n_rst = 1'b0;
    #1;
    exp_blk = 16'd0;
    checks++;
    if (in_ready !== 1'b1 || data_load !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0 ||
        data_in !== 128'd0 || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL reset_run ready=%b load=%b start=%b busy=%b data_in=%h blk_cnt=%h exp 1 0 0 0 0 0",
               in_ready, data_load, core_start, busy, data_in, blk_cnt);
    end
    step();
    step();
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (core_start !== 1'b0 || data_load !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_run_after cycle=%0d start=%b load=%b busy=%b exp 0 0 0", c, core_start, data_load, busy);
      end
    end
    // partial block discarded by reset
    send_word(32'hDEADBEEF);
    send_word(32'hFEEDF00D);
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || data_in !== 128'd0) begin
      errors++;
      $display("FAIL reset_partial busy=%b data_in=%h exp 0 0", busy, data_in);
    end
    send_block(BLK_B);
    checks++;
    if (data_load !== 1'b1 || data_in !== BLK_B) begin
      errors++;
      $display("FAIL reset_partial_reassemble load=%b data_in=%h exp 1 %h", data_load, data_in, BLK_B);
    end
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    exp_blk = exp_blk + 16'd1;
    checks++;
    if (blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL reset_partial_done blk_cnt=%h exp %h", blk_cnt, exp_blk);
    end
  endtask

`ifdef BLOCK_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    send_block(BLK_A);
    step();
    k = 0;
    while (timeout_err !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (k !== 255) begin
      errors++;
      $display("FAIL timeout_latency cycles=%0d exp 255", k);
    end
    checks++;
    if (in_ready !== 1'b1 || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL timeout_state ready=%b blk_cnt=%h exp 1 %h", in_ready, blk_cnt, exp_blk);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse timeout_err=%b exp 0", timeout_err);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    exp_blk   = 16'd0;
    n_rst     = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    abort     = 1'b0;
    core_done = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_wrap();
    test_reset_mid_run();
`ifdef BLOCK_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_load_ctrl.md
BLOCK_LOAD_CTRL -- requirements
Module: block_load_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  upstream word valid.
REQ-004 in_word  input  32  upstream data word.
REQ-005 in_ready  output  1  controller accepts in_word this cycle.
REQ-006 abort  input  1  synchronous flush of the current block.
REQ-007 data_load  output  1  load strobe to the 128-bit data register.
REQ-008 data_in  output  128  assembled block driven to the data register.
REQ-009 core_start  output  1  one-cycle start pulse to the downstream core.
REQ-010 core_done  input  1  downstream core finished the current block.
REQ-011 busy  output  1  block in progress: state != COLLECT, or word count != 0.
REQ-012 blk_cnt  output  16  completed-block counter.
REQ-013 timeout_err  output  1  one-cycle pulse on watchdog expiry; exists only under REQ-030.

Function
REQ-014 States SHALL be COLLECT, LOAD and RUN; outputs are decoded from registered state (Moore).
REQ-015 COLLECT: in_ready=1; each in_valid&&in_ready handshake stores in_word at slot word_cnt (2-bit) and increments word_cnt.
REQ-016 Slot mapping SHALL be word 0->data_in[127:96], 1->[95:64], 2->[63:32], 3->[31:0].
REQ-017 Handshake with word_cnt==3 SHALL move to LOAD next cycle and wrap word_cnt to 0; no handshake means no change.
REQ-018 LOAD SHALL last exactly one cycle: data_load=1, in_ready=0; data_in holds the assembled block; next state RUN.
REQ-019 data_in SHALL be stable from LOAD until the next slot-0 write.
REQ-020 RUN: in_ready=0, data_load=0; core_start=1 only in the first RUN cycle.
REQ-021 RUN with core_done=1 SHALL return to COLLECT and increment blk_cnt (16-bit wrap, 0xFFFF->0x0000); core_done in the core_start cycle counts.
REQ-022 core_done outside RUN SHALL be ignored.
REQ-023 abort=1 in any state SHALL go to COLLECT with word_cnt=0 and blk_cnt unchanged; it suppresses any same-cycle handshake capture.
REQ-024 abort during LOAD: data_load is still 1 that cycle, because it is state-decoded; no core_start follows.
REQ-025 Latency: data_load rises 1 cycle after the 4th handshake; core_start 1 cycle after data_load.

Reset
REQ-026 n_rst low SHALL immediately force state COLLECT, word_cnt=0, assembly register=0, blk_cnt=0.
REQ-027 Outputs during reset SHALL be in_ready=1, data_load=0, core_start=0, busy=0, data_in=0, timeout_err=0.
REQ-028 Reset mid-block SHALL discard partial words with no load or start pulse.
REQ-029 Normal operation SHALL resume on the first rising clk edge after n_rst deasserts.

Configuration
REQ-030 Macro BLOCK_LOAD_TIMEOUT_EN defined: an 8-bit watchdog clears on RUN entry and increments each RUN cycle without core_done.
REQ-031 With the macro, when the watchdog reaches 255 without core_done: timeout_err pulses 1 cycle, state returns to COLLECT, blk_cnt not incremented.
REQ-032 Macro undefined: no watchdog logic; RUN waits indefinitely; timeout_err port absent.

Verification
REQ-033 Words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF back-to-back -> data_load 1 cycle later, data_in=0x00112233_44556677_8899AABB_CCDDEEFF, core_start next cycle.
REQ-034 Same four words with in_valid gaps of 2 cycles -> identical data_in; in_ready low only in LOAD/RUN.
REQ-035 2 words, then abort with in_valid=1 -> word dropped, word_cnt=0, busy=0; next 4 words assemble correctly.
REQ-036 core_done=1 in the core_start cycle -> COLLECT next cycle, blk_cnt 0->1; preset blk_cnt=0xFFFF path -> wraps to 0x0000.
REQ-037 n_rst low in RUN with blk_cnt=5 -> all outputs at reset values, blk_cnt=0, no core_start after release.
REQ-038 With BLOCK_LOAD_TIMEOUT_EN and core_done held 0 -> timeout_err pulses 255 cycles after RUN entry, state COLLECT, blk_cnt unchanged.
